// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the two requester channels, the memory port and busy.
// The arbiter connects through slave; a requester/memory model would use master.
interface mem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req_c;
    logic              req_d;
    logic              we_c;
    logic              we_d;
    logic [DATA_W-1:0] addr_c;
    logic [DATA_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] wdata_d;
    logic              gnt_c;
    logic              gnt_d;
    logic              rvalid_c;
    logic              rvalid_d;
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] rdata_d;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req_c, req_d, we_c, we_d, addr_c, addr_d, wdata_c, wdata_d, mem_rdata,
        output gnt_c, gnt_d, rvalid_c, rvalid_d, rdata_c, rdata_d,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_c, req_d, we_c, we_d, addr_c, addr_d, wdata_c, wdata_d, mem_rdata,
        input  gnt_c, gnt_d, rvalid_c, rvalid_d, rdata_c, rdata_d,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a
// fixed read latency. One access in flight at a time; every output is a flop.
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_issue;
    logic              w_resp;
    logic              w_pick_d;
    logic              r_side;     // 1 = current access belongs to D
    logic              r_last_d;   // 1 = D was granted last
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_gnt_c;
    logic              r_gnt_d;
    logic              r_rvalid_c;
    logic              r_rvalid_d;
    logic [DATA_W-1:0] r_rdata_c;
    logic [DATA_W-1:0] r_rdata_d;
    logic              r_mem_en;
    logic              r_mem_we;
    logic              r_busy;

    // Next-state decode and winner selection
    always_comb begin
        w_next   = r_state;
        w_issue  = 1'b0;
        w_resp   = 1'b0;
        w_pick_d = bus.req_d & (~bus.req_c | ~r_last_d);
        case (r_state)
            IDLE: begin
                if (bus.req_c || bus.req_d) begin
                    w_next  = ISSUE;
                    w_issue = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_next = IDLE;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = RESP;
                    w_resp = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, latched request payload, round-robin pointer and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_side   <= 1'b0;
            r_last_d <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= {DATA_W{1'b0}};
            r_wdata  <= {DATA_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_side  <= w_pick_d;
                r_we    <= w_pick_d ? bus.we_d    : bus.we_c;
                r_addr  <= w_pick_d ? bus.addr_d  : bus.addr_c;
                r_wdata <= w_pick_d ? bus.wdata_d : bus.wdata_c;
            end else begin
                r_side  <= r_side;
                r_we    <= r_we;
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
            end
            if (r_state == ISSUE) begin
                r_last_d <= r_side;
            end else begin
                r_last_d <= r_last_d;
            end
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= {CNT_W{1'b0}};
            end
        end
    end

    // Registered pulses, strobes and captured read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_c    <= 1'b0;
            r_gnt_d    <= 1'b0;
            r_rvalid_c <= 1'b0;
            r_rvalid_d <= 1'b0;
            r_rdata_c  <= {DATA_W{1'b0}};
            r_rdata_d  <= {DATA_W{1'b0}};
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_gnt_c    <= w_issue & ~w_pick_d;
            r_gnt_d    <= w_issue &  w_pick_d;
            r_mem_en   <= w_issue;
            r_mem_we   <= w_issue & (w_pick_d ? bus.we_d : bus.we_c);
            r_rvalid_c <= w_resp & ~r_side;
            r_rvalid_d <= w_resp &  r_side;
            r_busy     <= (w_next != IDLE);
            if (w_resp && !r_side) begin
                r_rdata_c <= bus.mem_rdata;
            end else begin
                r_rdata_c <= r_rdata_c;
            end
            if (w_resp && r_side) begin
                r_rdata_d <= bus.mem_rdata;
            end else begin
                r_rdata_d <= r_rdata_d;
            end
        end
    end

    assign bus.gnt_c     = r_gnt_c;
    assign bus.gnt_d     = r_gnt_d;
    assign bus.rvalid_c  = r_rvalid_c;
    assign bus.rvalid_d  = r_rvalid_d;
    assign bus.rdata_c   = r_rdata_c;
    assign bus.rdata_d   = r_rdata_d;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 runs MEM_LAT=1, instance 1 MEM_LAT=4,
// each behind a small memory model; a negedge monitor pops expected grants/responses.
module tb_mem_arbiter;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    typedef struct packed {
        logic        side;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_c = 2'b00, req_d = 2'b00, we_c = 2'b00, we_d = 2'b00;
    logic [31:0] addr_c [2];
    logic [31:0] addr_d [2];
    logic [31:0] wdata_c [2];
    logic [31:0] wdata_d [2];
    logic [1:0]  gnt_c_w, gnt_d_w, rv_c_w, rv_d_w, en_w, we_w, busy_w;
    logic [31:0] maddr_w [2];
    logic [31:0] mwdata_w [2];
    logic [31:0] rdc_w [2];
    logic [31:0] rdd_w [2];

    exp_t gq0[$], gq1[$], rq0[$], rq1[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int gcyc_rd [2] = '{0, 0};
    int gnt_cnt [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int k);
        case (k)
            2:       return 32'h0BAD_F00D;
            4:       return 32'hDEAD_BEEF;
            default: return 32'hC0DE_0000 | 32'(k);
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        logic [31:0] mem  [16];
        logic [31:0] pipe [LAT];

        mem_arbiter_if #(.DATA_W(32)) bus ();
        mem_arbiter #(.DATA_W(32), .MEM_LAT(LAT)) u_dut (.clk(clk), .rst(rst), .bus(bus));

        assign bus.req_c     = req_c[g];
        assign bus.req_d     = req_d[g];
        assign bus.we_c      = we_c[g];
        assign bus.we_d      = we_d[g];
        assign bus.addr_c    = addr_c[g];
        assign bus.addr_d    = addr_d[g];
        assign bus.wdata_c   = wdata_c[g];
        assign bus.wdata_d   = wdata_d[g];
        assign bus.mem_rdata = pipe[LAT-1];
        assign gnt_c_w[g]    = bus.gnt_c;
        assign gnt_d_w[g]    = bus.gnt_d;
        assign rv_c_w[g]     = bus.rvalid_c;
        assign rv_d_w[g]     = bus.rvalid_d;
        assign en_w[g]       = bus.mem_en;
        assign we_w[g]       = bus.mem_we;
        assign busy_w[g]     = bus.busy;
        assign maddr_w[g]    = bus.mem_addr;
        assign mwdata_w[g]   = bus.mem_wdata;
        assign rdc_w[g]      = bus.rdata_c;
        assign rdd_w[g]      = bus.rdata_d;

        // Memory model: read data appears LAT cycles after the mem_en cycle
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
                for (int k = 0; k < LAT; k++) pipe[k] <= 32'h0;
            end else begin
                if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
                pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[5:2]] : 32'h0;
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_g(input int sel, input logic side, input logic we,
                          input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e = '{side: side, we: we, addr: addr, data: data};
        if (sel == 0) gq0.push_back(e); else gq1.push_back(e);
    endtask

    task automatic push_r(input int sel, input logic side, input logic [31:0] data);
        exp_t e;
        e = '{side: side, we: 1'b0, addr: 32'h0, data: data};
        if (sel == 0) rq0.push_back(e); else rq1.push_back(e);
    endtask

    task automatic mon(input int i);
        exp_t e;
        int   sz;
        int   lat;
        lat = (i == 0) ? LAT0 : LAT1;
        if (gnt_c_w[i] || gnt_d_w[i]) begin
            chk("gnt_onehot", 32'(gnt_c_w[i] & gnt_d_w[i]), 32'd0);
            chk("gnt_rvalid_excl", 32'(rv_c_w[i] | rv_d_w[i]), 32'd0);
            sz = (i == 0) ? gq0.size() : gq1.size();
            chk("gnt_expected", 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                if (i == 0) e = gq0.pop_front(); else e = gq1.pop_front();
                chk("gnt_side", 32'(gnt_d_w[i]), 32'(e.side));
                chk("mem_en_at_gnt", 32'(en_w[i]), 32'd1);
                chk("mem_we_at_gnt", 32'(we_w[i]), 32'(e.we));
                chk("mem_addr", maddr_w[i], e.addr);
                chk("mem_wdata", mwdata_w[i], e.data);
                if (!e.we) gcyc_rd[i] = cyc;
            end
            gnt_cnt[i]++;
        end else begin
            chk("mem_en_without_gnt", 32'(en_w[i]), 32'd0);
            chk("mem_we_idle", 32'(we_w[i]), 32'd0);
        end
        if (rv_c_w[i] || rv_d_w[i]) begin
            chk("rvalid_onehot", 32'(rv_c_w[i] & rv_d_w[i]), 32'd0);
            sz = (i == 0) ? rq0.size() : rq1.size();
            chk("rvalid_expected", 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                if (i == 0) e = rq0.pop_front(); else e = rq1.pop_front();
                chk("rvalid_side", 32'(rv_d_w[i]), 32'(e.side));
                chk("rdata", e.side ? rdd_w[i] : rdc_w[i], e.data);
                chk("read_latency", 32'(cyc - gcyc_rd[i]), 32'(lat + 1));
            end
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int sel, input logic side, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (side) begin
            req_d[sel] = 1'b1; we_d[sel] = we; addr_d[sel] = addr; wdata_d[sel] = wdata;
        end else begin
            req_c[sel] = 1'b1; we_c[sel] = we; addr_c[sel] = addr; wdata_c[sel] = wdata;
        end
    endtask

    task automatic wait_gnt(input int sel, input logic side, output int gc);
        gc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((side ? gnt_d_w[sel] : gnt_c_w[sel]) === 1'b1) begin
                gc = cyc;
                break;
            end
        end
        chk("gnt_timeout", 32'(gc >= 0), 32'd1);
    endtask

    task automatic wait_idle(input int sel);
        int ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy_w[sel] === 1'b0) begin
                ok = 1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_zero(input int sel);
        chk("reset_ctrl", 32'({gnt_c_w[sel], gnt_d_w[sel], rv_c_w[sel], rv_d_w[sel],
                               en_w[sel], we_w[sel], busy_w[sel]}), 32'd0);
        chk("reset_data", maddr_w[sel] | mwdata_w[sel] | rdc_w[sel] | rdd_w[sel], 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gc, g1, g2, base, ok, seen;
        for (int i = 0; i < 2; i++) begin
            addr_c[i] = 32'h0; addr_d[i] = 32'h0; wdata_c[i] = 32'h0; wdata_d[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        step();
        rst = 1'b1;

        // Single read on C, MEM_LAT=1: gnt at cycle 1, rvalid at cycle 3
        step();
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        push_g(0, 1'b0, 1'b0, 32'h10, 32'h0);
        push_r(0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk); chk("t1_busy_c0", 32'(busy_w[0]), 32'd0);
        step(); req_c[0] = 1'b0;
        @(negedge clk); chk("t1_gnt_c1", 32'(gnt_c_w[0]), 32'd1);
        chk("t1_busy_c1", 32'(busy_w[0]), 32'd1);
        @(negedge clk); chk("t1_busy_c2", 32'(busy_w[0]), 32'd1);
        chk("t1_no_rvalid_c2", 32'(rv_c_w[0]), 32'd0);
        @(negedge clk); chk("t1_rvalid_c3", 32'(rv_c_w[0]), 32'd1);
        chk("t1_rdata_c3", rdc_w[0], 32'hDEAD_BEEF);
        chk("t1_busy_c3", 32'(busy_w[0]), 32'd1);
        @(negedge clk); chk("t1_busy_c4", 32'(busy_w[0]), 32'd0);

        // Single write on D
        step();
        set_req(0, 1'b1, 1'b1, 32'h4, 32'h1234);
        push_g(0, 1'b1, 1'b1, 32'h4, 32'h1234);
        wait_gnt(0, 1'b1, gc);
        step(); req_d[0] = 1'b0; we_d[0] = 1'b0;
        @(negedge clk);
        chk("t2_idle_next", 32'(busy_w[0]), 32'd0);
        chk("t2_mem_en_off", 32'(en_w[0]), 32'd0);
        chk("t2_addr_hold", maddr_w[0], 32'h4);
        chk("t2_wdata_hold", mwdata_w[0], 32'h1234);
        chk("t2_no_rvalid", 32'(rv_c_w[0] | rv_d_w[0]), 32'd0);

        // Continuous tie of reads: C, D, C, D
        step();
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int k = 0; k < 2; k++) begin
            push_g(0, 1'b0, 1'b0, 32'h10, 32'h0); push_r(0, 1'b0, 32'hDEAD_BEEF);
            push_g(0, 1'b1, 1'b0, 32'h4, 32'h0);  push_r(0, 1'b1, 32'h1234);
        end
        base = gnt_cnt[0];
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (gnt_cnt[0] >= base + 4) begin
                ok = 1;
                break;
            end
        end
        chk("t3_tie_timeout", 32'(ok), 32'd1);
        step(); req_c[0] = 1'b0; req_d[0] = 1'b0;
        wait_idle(0);

        // MEM_LAT=4: D read first, C queued behind it
        step();
        set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
        push_g(1, 1'b1, 1'b0, 32'h8, 32'h0);  push_r(1, 1'b1, 32'h0BAD_F00D);
        step();
        set_req(1, 1'b0, 1'b0, 32'h10, 32'h0);
        push_g(1, 1'b0, 1'b0, 32'h10, 32'h0); push_r(1, 1'b0, 32'hDEAD_BEEF);
        wait_gnt(1, 1'b1, g1);
        step(); req_d[1] = 1'b0;
        wait_gnt(1, 1'b0, g2);
        chk("t4_second_issue_gap", 32'(g2 - g1), 32'd7);
        step(); req_c[1] = 1'b0;
        wait_idle(1);

        // Reset during WAIT abandons the read
        step();
        set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
        push_g(1, 1'b1, 1'b0, 32'h8, 32'h0);
        wait_gnt(1, 1'b1, gc);
        step(); req_d[1] = 1'b0; rst = 1'b0;
        @(negedge clk);
        check_zero(1);
        step(); rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_idle_after_reset", 32'(busy_w[1]), 32'd0);
        step();
        set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
        push_g(1, 1'b1, 1'b0, 32'h10, 32'h0); push_r(1, 1'b1, 32'hDEAD_BEEF);
        wait_gnt(1, 1'b1, gc);
        step(); req_d[1] = 1'b0;
        wait_idle(1);

        // C raises req only during D's ISSUE and drops before IDLE sampling
        step();
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h55AA);
        push_g(0, 1'b1, 1'b1, 32'h20, 32'h55AA);
        step();
        req_d[0] = 1'b0; we_d[0] = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk); chk("t6_gnt_d", 32'(gnt_d_w[0]), 32'd1);
        step(); req_c[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (gnt_c_w[0] === 1'b1) seen++;
        end
        chk("t6_no_gnt_c", 32'(seen), 32'd0);

        chk("gq0_drained", 32'(gq0.size()), 32'd0);
        chk("gq1_drained", 32'(gq1.size()), 32'd0);
        chk("rq0_drained", 32'(rq0.size()), 32'd0);
        chk("rq1_drained", 32'(rq1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
